// File: rtl/cp0_exception_unit_pkg.sv
// CP0 register numbers, exception codes, Status/Cause bit positions and the
// exception FSM state type shared by the CP0 exception unit files.
package cp0_exception_unit_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  localparam int ST_IE_BIT    = 0;
  localparam int ST_EXL_BIT   = 1;
  localparam int IM_LSB       = 10;
  localparam int IP_LSB       = 10;
  localparam int TIMER_BIT    = 15;
  localparam int EXC_CODE_LSB = 2;
  localparam int EXC_CODE_MSB = 6;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/cp0_exception_unit_irq_sync_edge.sv
// One interrupt line: SYNC_STAGES-deep synchroniser followed by a rising-edge
// detector producing a single-cycle pulse.
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_irq,
  output logic o_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/cp0_exception_unit.sv
// CP0 register file and exception sequencer (syscall, interrupt, ERET).
// Optional Count/Compare timer interrupt enabled by macro CP0_TIMER_EN.
//   state      | meaning
//   ST_NORMAL  | normal execution, interrupts may be taken (Status.EXL=0)
//   ST_HANDLER | inside exception handler (Status.EXL=1)
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter int          IRQ_N       = 4,
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0800,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic [IRQ_N-1:0] i_irq,
  input  logic             i_sys,
  input  logic             i_exce_ret,
  input  logic             i_mfc0,
  input  logic             i_mtc0,
  input  logic [4:0]       i_rd_sel,
  input  logic [31:0]      i_wdata,
  input  logic [31:0]      i_pc_cur,
  input  logic [31:0]      i_pc_next,
  output logic [31:0]      o_rdata,
  output logic             o_redirect,
  output logic [31:0]      o_redirect_pc,
  output logic             o_exl
);

  localparam int IP_MSB = IP_LSB + IRQ_N - 1;
  localparam int IM_MSB = IM_LSB + IRQ_N - 1;

  cp0_state_e       r_state;
  logic             r_ie;
  logic [IRQ_N-1:0] r_im;
  logic [IRQ_N-1:0] r_ip;
  logic [4:0]       r_exc_code;
  logic [31:0]      r_epc;
  logic [31:0]      r_count;

  logic [IRQ_N-1:0] w_irq_pulse;
  logic [IRQ_N-1:0] w_ip_keep;
  logic             w_exl;
  logic             w_go;
  logic             w_int_req;
  logic             w_take_sys;
  logic             w_take_eret;
  logic             w_take_int;
  logic             w_wr_status;
  logic             w_wr_cause;
  logic             w_wr_epc;
  logic             w_wr_count;
  logic [31:0]      w_status;
  logic [31:0]      w_cause;
  logic [31:0]      w_compare;
  logic             w_tip;
  logic             w_tim;

  for (genvar gi = 0; gi < IRQ_N; gi++) begin : g_irq
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_irq  (i_irq[gi]),
      .o_pulse(w_irq_pulse[gi])
    );
  end

  assign w_exl     = (r_state == ST_HANDLER);
  assign w_go      = ~i_stall & ~i_rst;
  assign w_int_req = r_ie & ~w_exl & (|({w_tip, r_ip} & {w_tim, r_im}));

  // Priority: syscall, then ERET, then interrupt.
  assign w_take_sys  = w_go & i_sys;
  assign w_take_eret = w_go & ~i_sys & i_exce_ret;
  assign w_take_int  = w_go & ~i_sys & ~i_exce_ret & w_int_req;

  assign w_wr_status = w_go & i_mtc0 & (i_rd_sel == CP0_STATUS);
  assign w_wr_cause  = w_go & i_mtc0 & (i_rd_sel == CP0_CAUSE);
  assign w_wr_epc    = w_go & i_mtc0 & (i_rd_sel == CP0_EPC);
  assign w_wr_count  = w_go & i_mtc0 & (i_rd_sel == CP0_COUNT);

  // Software may only clear IP bits; a same-cycle edge still sets them.
  assign w_ip_keep = w_wr_cause ? i_wdata[IP_MSB:IP_LSB] : '1;

  assign o_redirect    = w_take_sys | w_take_eret | w_take_int;
  assign o_redirect_pc = w_take_eret ? r_epc : EXC_VECTOR;
  assign o_exl         = w_exl;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_NORMAL;
      r_ie       <= 1'b0;
      r_im       <= '0;
      r_ip       <= '0;
      r_exc_code <= '0;
      r_epc      <= '0;
      r_count    <= '0;
    end else begin
      r_ip <= (r_ip & w_ip_keep) | w_irq_pulse;
      if (!i_stall) begin
        r_count <= w_wr_count ? i_wdata : r_count + 32'd1;
        if (w_wr_status) begin
          r_ie    <= i_wdata[ST_IE_BIT];
          r_im    <= i_wdata[IM_MSB:IM_LSB];
          r_state <= cp0_state_e'(i_wdata[ST_EXL_BIT]);
        end
        if (w_wr_cause) r_exc_code <= i_wdata[EXC_CODE_MSB:EXC_CODE_LSB];
        if (w_wr_epc)   r_epc      <= i_wdata;
        // Exception entry/return overrides a same-cycle mtc0 of these fields.
        if (w_take_sys) begin
          r_epc      <= i_pc_cur + 32'd4;
          r_exc_code <= EXC_SYS;
          r_state    <= ST_HANDLER;
        end else if (w_take_eret) begin
          r_state <= ST_NORMAL;
        end else if (w_take_int) begin
          r_epc      <= i_pc_next;
          r_exc_code <= EXC_INT;
          r_state    <= ST_HANDLER;
        end
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] r_compare;
  logic        r_tip;
  logic        r_tim;
  logic        w_wr_compare;

  assign w_wr_compare = w_go & i_mtc0 & (i_rd_sel == CP0_COMPARE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_compare <= 32'hFFFF_FFFF;
      r_tip     <= 1'b0;
      r_tim     <= 1'b0;
    end else begin
      if (w_wr_compare) begin
        r_compare <= i_wdata;
        r_tip     <= 1'b0;
      end else if (r_count == r_compare) begin
        r_tip <= 1'b1;
      end
      if (w_wr_status) r_tim <= i_wdata[TIMER_BIT];
    end
  end

  assign w_compare = r_compare;
  assign w_tip     = r_tip;
  assign w_tim     = r_tim;
`else
  assign w_compare = '0;
  assign w_tip     = 1'b0;
  assign w_tim     = 1'b0;
`endif

  always_comb begin
    w_status                 = '0;
    w_status[ST_IE_BIT]      = r_ie;
    w_status[ST_EXL_BIT]     = w_exl;
    w_status[IM_MSB:IM_LSB]  = r_im;
    w_status[TIMER_BIT]      = w_status[TIMER_BIT] | w_tim;
    w_cause                  = '0;
    w_cause[IP_MSB:IP_LSB]   = r_ip;
    w_cause[TIMER_BIT]       = w_cause[TIMER_BIT] | w_tip;
    w_cause[EXC_CODE_MSB:EXC_CODE_LSB] = r_exc_code;
  end

  always_comb begin
    o_rdata = '0;
    if (i_mfc0) begin
      case (i_rd_sel)
        CP0_COUNT:   o_rdata = r_count;
        CP0_COMPARE: o_rdata = w_compare;
        CP0_STATUS:  o_rdata = w_status;
        CP0_CAUSE:   o_rdata = w_cause;
        CP0_EPC:     o_rdata = r_epc;
        default:     o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed-vector bench for cp0_exception_unit; timer checks follow CP0_TIMER_EN.
module tb_cp0_exception_unit;

  localparam int IRQ_N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             stall;
  logic [IRQ_N-1:0] irq;
  logic             sys;
  logic             exce_ret;
  logic             mfc0;
  logic             mtc0;
  logic [4:0]       rd_sel;
  logic [31:0]      wdata;
  logic [31:0]      pc_cur;
  logic [31:0]      pc_next;
  logic [31:0]      rdata;
  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             exl;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_cnt;

  cp0_exception_unit #(
    .IRQ_N      (IRQ_N),
    .EXC_VECTOR (32'h0000_0800),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_stall      (stall),
    .i_irq        (irq),
    .i_sys        (sys),
    .i_exce_ret   (exce_ret),
    .i_mfc0       (mfc0),
    .i_mtc0       (mtc0),
    .i_rd_sel     (rd_sel),
    .i_wdata      (wdata),
    .i_pc_cur     (pc_cur),
    .i_pc_next    (pc_next),
    .o_rdata      (rdata),
    .o_redirect   (redirect),
    .o_redirect_pc(redirect_pc),
    .o_exl        (exl)
  );

  always #5 clk = ~clk;

  // Reference Count: one tick per non-stalled cycle out of reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= '0;
    else if (!stall) m_cnt <= m_cnt + 32'd1;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] sel, output logic [31:0] v);
    @(negedge clk);
    mfc0   = 1'b1;
    rd_sel = sel;
    #1;
    v    = rdata;
    mfc0 = 1'b0;
  endtask

  task automatic wr(input logic [4:0] sel, input logic [31:0] d);
    @(negedge clk);
    mtc0   = 1'b1;
    rd_sel = sel;
    wdata  = d;
    @(negedge clk);
    mtc0 = 1'b0;
  endtask

  task automatic wait_redirect(output int k);
    k = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (redirect) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          k;

    rst = 1'b1; stall = 1'b0; irq = '0; sys = 1'b0; exce_ret = 1'b0;
    mfc0 = 1'b0; mtc0 = 1'b0; rd_sel = '0; wdata = '0;
    pc_cur = '0; pc_next = 32'h0000_0100;
    repeat (3) @(negedge clk);
    #1;
    check_vec("rst_redirect", 32'(redirect), 32'd0);
    check_vec("rst_redirect_pc", redirect_pc, 32'h0000_0800);
    check_vec("rst_exl", 32'(exl), 32'd0);
    check_vec("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    repeat (9) @(negedge clk);
    rd(5'd9, v);  check_vec("count_10", v, 32'd10);
    rd(5'd12, v); check_vec("status_rst", v, 32'd0);
    rd(5'd13, v); check_vec("cause_rst", v, 32'd0);
    rd(5'd14, v); check_vec("epc_rst", v, 32'd0);

    // syscall entry and return
    @(negedge clk);
    sys = 1'b1; pc_cur = 32'h0000_0040;
    #1;
    check_vec("sys_redirect", 32'(redirect), 32'd1);
    check_vec("sys_redirect_pc", redirect_pc, 32'h0000_0800);
    @(negedge clk);
    sys = 1'b0;
    #1;
    check_vec("sys_exl", 32'(exl), 32'd1);
    rd(5'd14, v); check_vec("sys_epc", v, 32'h0000_0044);
    rd(5'd13, v); check_vec("sys_cause", v, 32'h0000_0020);
    @(negedge clk);
    exce_ret = 1'b1;
    #1;
    check_vec("eret_redirect", 32'(redirect), 32'd1);
    check_vec("eret_pc", redirect_pc, 32'h0000_0044);
    @(negedge clk);
    exce_ret = 1'b0;
    #1;
    check_vec("eret_exl", 32'(exl), 32'd0);

    // external interrupt on irq[0]
    wr(5'd12, 32'h0000_0401);
    rd(5'd12, v); check_vec("status_wr", v, 32'h0000_0401);
    @(negedge clk);
    irq[0] = 1'b1;
    wait_redirect(k);
    check_vec("irq_latency", 32'(k), 32'd3);
    check_vec("irq_redirect_pc", redirect_pc, 32'h0000_0800);
    @(posedge clk);
    #1;
    irq[0] = 1'b0;
    check_vec("irq_exl", 32'(exl), 32'd1);
    rd(5'd14, v); check_vec("irq_epc", v, 32'h0000_0100);
    rd(5'd13, v); check_vec("irq_cause", v, 32'h0000_0400);
    repeat (3) @(negedge clk);
    rd(5'd13, v); check_vec("ip_sticky", v, 32'h0000_0400);
    wr(5'd13, 32'd0);
    rd(5'd13, v); check_vec("ip_cleared", v, 32'd0);
    @(negedge clk);
    exce_ret = 1'b1;
    #1;
    check_vec("irq_eret_pc", redirect_pc, 32'h0000_0100);
    @(negedge clk);
    exce_ret = 1'b0;
    #1;
    check_vec("irq_eret_exl", 32'(exl), 32'd0);
    check_vec("no_reentry", 32'(redirect), 32'd0);

    // syscall and interrupt in the same cycle
    @(negedge clk);
    irq[0] = 1'b1;
    wait_redirect(k);
    check_vec("race_irq_latency", 32'(k), 32'd3);
    sys = 1'b1; pc_cur = 32'h0000_0200;
    #1;
    check_vec("race_redirect_pc", redirect_pc, 32'h0000_0800);
    @(posedge clk);
    #1;
    sys = 1'b0; irq[0] = 1'b0;
    check_vec("race_exl", 32'(exl), 32'd1);
    rd(5'd13, v); check_vec("race_cause", v, 32'h0000_0420);
    rd(5'd14, v); check_vec("race_epc", v, 32'h0000_0204);
    @(negedge clk);
    exce_ret = 1'b1;
    #1;
    check_vec("race_eret_pc", redirect_pc, 32'h0000_0204);
    @(negedge clk);
    exce_ret = 1'b0;
    #1;
    check_vec("pend_redirect", 32'(redirect), 32'd1);
    check_vec("pend_redirect_pc", redirect_pc, 32'h0000_0800);
    @(posedge clk);
    #1;
    check_vec("pend_exl", 32'(exl), 32'd1);
    rd(5'd13, v); check_vec("pend_cause", v, 32'h0000_0400);
    rd(5'd14, v); check_vec("pend_epc", v, 32'h0000_0100);
    wr(5'd13, 32'd0);
    @(negedge clk);
    exce_ret = 1'b1;
    @(negedge clk);
    exce_ret = 1'b0;
    #1;
    check_vec("pend_eret_exl", 32'(exl), 32'd0);

    // stalled syscall
    @(negedge clk);
    stall = 1'b1; sys = 1'b1; pc_cur = 32'h0000_0300;
    mfc0 = 1'b1; rd_sel = 5'd14;
    #1;
    check_vec("stall_redirect", 32'(redirect), 32'd0);
    check_vec("stall_epc_a", rdata, 32'h0000_0100);
    repeat (3) @(negedge clk);
    #1;
    check_vec("stall_epc_b", rdata, 32'h0000_0100);
    check_vec("stall_exl", 32'(exl), 32'd0);
    rd_sel = 5'd9;
    #1;
    check_vec("stall_count", rdata, m_cnt);
    mfc0 = 1'b0;
    stall = 1'b0;
    #1;
    check_vec("unstall_redirect", 32'(redirect), 32'd1);
    @(posedge clk);
    #1;
    sys = 1'b0;
    check_vec("unstall_exl", 32'(exl), 32'd1);
    rd(5'd14, v); check_vec("unstall_epc", v, 32'h0000_0304);
    rd(5'd9, v);  check_vec("count_model", v, m_cnt);

    // reset while inside the handler
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_vec("midrst_exl", 32'(exl), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd(5'd14, v); check_vec("midrst_epc", v, 32'd0);
    rd(5'd12, v); check_vec("midrst_status", v, 32'd0);

    // Compare register / timer interrupt
    wr(5'd11, 32'd20);
`ifdef CP0_TIMER_EN
    rd(5'd11, v); check_vec("compare_rd", v, 32'd20);
    rd(5'd13, v); check_vec("timer_early", v, 32'd0);
`else
    rd(5'd11, v); check_vec("compare_absent", v, 32'd0);
`endif
    for (int i = 0; i < 100 && m_cnt < 32'd24; i++) @(negedge clk);
    check_vec("count_past_20", 32'(m_cnt >= 32'd24), 32'd1);
`ifdef CP0_TIMER_EN
    rd(5'd13, v); check_vec("timer_ip", v, 32'h0000_8000);
    wr(5'd11, 32'd20);
    rd(5'd13, v); check_vec("timer_clr", v, 32'd0);
`else
    rd(5'd13, v); check_vec("timer_ip_absent", v, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- Coprocessor-0 and exception sequencer sitting directly downstream of the instruction decoder.
- Consumes the decoder's sys, exce_ret, mfc0 and mtc0 strobes plus external interrupt lines.
- Holds the Status, Cause, EPC and Count registers.
- Tells the PC-select logic when and where to redirect: exception vector on entry, EPC on return.

Parameters:
- IRQ_N, 4, number of external interrupt lines (1..6); map to Cause.IP[IRQ_N+9:10].
- EXC_VECTOR, 32'h0000_0800, handler entry address.
- SYNC_STAGES, 2, synchroniser depth on irq inputs (>=2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- stall  in  1  instruction in flight is not committing; blocks all state updates and exception entry
- irq  in  IRQ_N  asynchronous external interrupt requests, rising-edge sensitive
- sys  in  1  syscall decoded
- exce_ret  in  1  ERET decoded
- mfc0  in  1  move-from-CP0 decoded
- mtc0  in  1  move-to-CP0 decoded
- rd_sel  in  5  CP0 register number (instruction rd field)
- wdata  in  32  rt value for mtc0
- pc_cur  in  32  address of current instruction
- pc_next  in  32  sequential/branch-resolved next PC of current instruction
- rdata  out  32  CP0 read data for mfc0
- redirect  out  1  PC must load redirect_pc this cycle
- redirect_pc  out  32  EXC_VECTOR or EPC
- exl  out  1  in-handler flag (Status.EXL)

Behaviour:
- Register map:
  - 9 Count: free-running, +1 per non-stalled cycle, wraps 32'hFFFF_FFFF -> 0.
  - 12 Status: bit0 IE, bit1 EXL, [IRQ_N+9:10] IM; other bits read 0.
  - 13 Cause: [IRQ_N+9:10] IP, [6:2] ExcCode; other bits read 0.
  - 14 EPC.
  - Unmapped numbers read 0; writes to them are ignored.
- Reset values: Status=0, Cause=0, EPC=0, Count=0, synchroniser and edge flops 0, rdata=0, redirect=0, redirect_pc=EXC_VECTOR, exl=0. Reset mid-handler discards all state.
- Interrupt capture:
  - irq passes through SYNC_STAGES flops, then a rising-edge detector.
  - A detected edge sets its IP bit; the bit stays set until software clears it.
  - Capture continues during stall.
  - Software clear: mtc0 to Cause writing 0 to an IP bit clears it.
  - If an edge and a software clear hit the same bit in the same cycle, set wins.
- Two-state FSM mirrored by Status.EXL:
  - NORMAL -> HANDLER on exception entry.
  - HANDLER -> NORMAL on ERET.
- Interrupt request: int_req = IE & ~EXL & |(IP & IM), evaluated on pre-edge register values.
- Entry, when ~stall, same cycle (combinational redirect; registers update at edge), priority order:
  - sys: EPC <= pc_cur+4, ExcCode <= 8, EXL <= 1, redirect=1, redirect_pc=EXC_VECTOR.
  - else int_req: EPC <= pc_next, ExcCode <= 0, EXL <= 1, same redirect. The current instruction commits.
  - A sys taken in HANDLER state is still taken, overwriting EPC (nested syscall unsupported by software convention).
  - An interrupt losing to sys stays pending in IP.
- ERET (~stall):
  - redirect=1, redirect_pc=EPC (pre-edge value), EXL <= 0.
  - Issued with EXL=0, it still redirects to EPC.
  - ERET takes priority over int_req in the same cycle; the interrupt re-evaluates next cycle.
- mtc0 (~stall): write takes effect at the clock edge. An exception entry in the same cycle overrides the written EPC/EXL/ExcCode fields.
- mfc0: rdata = selected register, combinational. rdata=0 when mfc0=0.
- stall=1: redirect=0; no register other than the IP capture changes.

Optional Feature:
- Macro CP0_TIMER_EN.
- With it defined:
  - Adds Compare register 11 (reset 32'hFFFF_FFFF).
  - When Count == Compare, Cause bit 15 (timer IP) sets. It is masked by Status bit 15.
  - Any mtc0 to Compare clears bit 15.
- Without it:
  - Register 11 reads 0 and writes are ignored.
  - Bit 15 is always 0.
  - No comparator is synthesised.

Decomposition:
- Shared header cp0_defs.vh holds:
  - register numbers (CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14)
  - ExcCode values (EXC_INT=0, EXC_SYS=8)
  - Status/Cause bit positions
- Sub-module irq_sync_edge: per-line synchroniser plus rising-edge pulse, instantiated IRQ_N-wide.

Test Plan:
- Reset, then mfc0 of regs 12/13/14 -> rdata 0. Ten non-stalled cycles later, reg 9 reads 10.
- sys at pc_cur=32'h0000_0040 -> redirect=1, redirect_pc=32'h800. Next cycle: EPC=32'h44, Cause.ExcCode=8, exl=1.
- mtc0 Status=32'h0000_0401, pulse irq[0], pc_next=32'h0000_0100:
  - Entry exactly SYNC_STAGES+1 cycles after the edge, with EPC=32'h100.
  - ERET -> redirect_pc=32'h100, exl=0.
  - Cause IP bit 10 stays set until mtc0 writes it 0.
- Same-cycle sys and pending enabled interrupt -> ExcCode=8, IP bit remains 1. After ERET with IE=1, interrupt entry follows.
- stall=1 with sys asserted -> redirect=0, EPC and Count unchanged. Deassert stall -> entry occurs.
- CP0_TIMER_EN: Compare=32'd20 from reset -> Cause bit 15 sets when Count reaches 20. mtc0 Compare clears it. Without the macro, reg 11 reads 0.
